// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: command sequencer in front of an 8-bit hardware stack.
// It accepts one stack-machine command at a time over a valid/ready handshake.
// Each command becomes a sequence of push/pop/tos strobes, with the ALU step in between.
// Underflow and overflow are caught at accept time from the occupancy count,
// so a rejected command never touches the stack.
// Optional feature: define STACK_SEQ_SWAP_EN to enable opcode 111 as SWAP.
// When it is undefined, opcode 111 is rejected with rsp_err.
module stack_op_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned DEPTH_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [DW-1:0]      cmd_imm,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic [DEPTH_W-1:0] depth,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_tos,
  output logic [DW-1:0]      stk_din,
  input  logic [DW-1:0]      stk_dout
);

  localparam logic [2:0] OpPush = 3'b000;
  localparam logic [2:0] OpPop  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpNot  = 3'b101;
  localparam logic [2:0] OpDup  = 3'b110;
`ifdef STACK_SEQ_SWAP_EN
  localparam logic [2:0] OpSwap = 3'b111;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StRd1,
    StRd2,
    StTos,
    StLat,
    StWr,
`ifdef STACK_SEQ_SWAP_EN
    StWr2,
`endif
    StRsp
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [DW-1:0]        a_q, a_d;     // first popped operand (top of stack)
  logic [DW-1:0]        res_q, res_d; // result / immediate / popped value
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 err_q, err_d;
  logic                 reject;
  logic                 two_pop;
  logic                 is_swap;

  // Decide at accept time whether the command would underflow or overflow
  always_comb begin
    reject = 1'b0;
    case (cmd_op)
      OpPush, OpDup:       reject = (depth_q == DEPTH_W'(DEPTH));
      OpPop, OpNot:        reject = (depth_q == '0);
      OpAdd, OpSub, OpAnd: reject = (depth_q < DEPTH_W'(2));
`ifdef STACK_SEQ_SWAP_EN
      OpSwap:              reject = (depth_q < DEPTH_W'(2));
`endif
      default:             reject = 1'b1;
    endcase
  end

  // Classify the captured opcode
  always_comb begin
    two_pop = (op_q == OpAdd) || (op_q == OpSub) || (op_q == OpAnd);
    is_swap = 1'b0;
`ifdef STACK_SEQ_SWAP_EN
    is_swap = (op_q == OpSwap);
    two_pop = two_pop || is_swap;
`endif
  end

  // Next-state, operand capture, ALU and occupancy update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    res_d   = res_q;
    depth_d = depth_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          err_d = reject;
          res_d = '0;
          if (reject) begin
            state_d = StRsp;
          end else if (cmd_op == OpPush) begin
            res_d   = cmd_imm;
            state_d = StWr;
          end else if (cmd_op == OpDup) begin
            state_d = StTos;
          end else begin
            state_d = StRd1;
          end
        end
      end
      StRd1:   state_d = two_pop ? StRd2 : StLat;
      StRd2: begin
        a_d     = stk_dout;
        state_d = StLat;
      end
      StTos:   state_d = StLat;
      StLat: begin
        state_d = StWr;
        case (op_q)
          OpPop: begin
            res_d   = stk_dout;
            state_d = StRsp;
          end
          OpAdd:   res_d = stk_dout + a_q;
          OpSub:   res_d = stk_dout - a_q;
          OpAnd:   res_d = stk_dout & a_q;
          OpNot:   res_d = ~stk_dout;
          default: res_d = stk_dout; // DUP value, or B for SWAP
        endcase
      end
`ifdef STACK_SEQ_SWAP_EN
      StWr:    state_d = is_swap ? StWr2 : StRsp;
      StWr2:   state_d = StRsp;
`else
      StWr:    state_d = StRsp;
`endif
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Occupancy changes only on the edge that completes a successful command
    if (state_q != StIdle && state_q != StRsp && state_d == StRsp) begin
      case (op_q)
        OpPush, OpDup:              depth_d = depth_q + DEPTH_W'(1);
        OpPop, OpAdd, OpSub, OpAnd: depth_d = depth_q - DEPTH_W'(1);
        default:                    depth_d = depth_q;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpPush;
      a_q     <= '0;
      res_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      res_q   <= res_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Moore output decode; the SWAP first write pushes A, every other write pushes res_q
  always_comb begin
    cmd_ready = (state_q == StIdle);
    rsp_valid = (state_q == StRsp);
    rsp_err   = (state_q == StRsp) && err_q;
    rsp_data  = res_q;
    depth     = depth_q;
    stk_pop   = (state_q == StRd1) || (state_q == StRd2);
    stk_tos   = (state_q == StTos);
    stk_push  = (state_q == StWr);
    stk_din   = res_q;
`ifdef STACK_SEQ_SWAP_EN
    stk_push  = stk_push || (state_q == StWr2);
    if (state_q == StWr && is_swap) stk_din = a_q;
`endif
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench for stack_op_sequencer.
// It includes a behavioural stack that sits behind the DUT.
// Directed vectors come from a table, and hand-written sequences cover full-stack,
// held-valid and mid-command reset behaviour.
// A randomized phase is checked against a queue-based reference model.
module tb_stack_op_sequencer;
  localparam int DW      = 8;
  localparam int DEPTH   = 32;
  localparam int DEPTH_W = 6;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [DW-1:0]      cmd_imm;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic [DEPTH_W-1:0] depth;
  logic               stk_push;
  logic               stk_pop;
  logic               stk_tos;
  logic [DW-1:0]      stk_din;
  logic [DW-1:0]      stk_dout;

  stack_op_sequencer #(.DW(DW), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_imm   (cmd_imm),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .depth     (depth),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_tos   (stk_tos),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural hardware stack with registered read data
  logic [DW-1:0] hw_stk[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_stk.delete();
      stk_dout <= '0;
    end else begin
      if (stk_push) hw_stk.push_back(stk_din);
      if (stk_pop) begin
        if (hw_stk.size() > 0) stk_dout <= hw_stk.pop_back();
        else stk_dout <= '0;
      end
      if (stk_tos) begin
        if (hw_stk.size() > 0) stk_dout <= hw_stk[$];
        else stk_dout <= '0;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe trace of the last command: {push, pop, tos} per busy cycle
  logic [2:0] trace[0:31];
  int         trace_len;

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] imm,
                         output logic [7:0] data, output logic err,
                         output int nstb, output int multi);
    int n;
    int c;
    data = '0;
    err = 1'b0;
    nstb = 0;
    multi = 0;
    trace_len = 0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) break;
      c = int'(stk_push) + int'(stk_pop) + int'(stk_tos);
      nstb += c;
      if (c > 1) multi++;
      trace[trace_len] = {stk_push, stk_pop, stk_tos};
      trace_len++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    data = rsp_data;
    err = rsp_err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int exp_strobes(input logic [2:0] op, input logic err);
    if (err) return 0;
    case (op)
      OP_PUSH, OP_POP:        return 1;
      OP_ADD, OP_SUB, OP_AND: return 3;
      OP_NOT, OP_DUP:         return 2;
      default:                return 4; // SWAP: pop, pop, push, push
    endcase
  endfunction

  // Reference model: the stack as a queue; the back of the queue is the top
  logic [7:0] mq[$];
  task automatic model_cmd(input logic [2:0] op, input logic [7:0] imm,
                           output logic [7:0] d, output logic e);
    logic [7:0] a, b, r;
    int n;
    n = mq.size();
    d = 8'h00;
    e = 1'b0;
    r = 8'h00;
    case (op)
      OP_PUSH: if (n == DEPTH) e = 1'b1; else begin mq.push_back(imm); d = imm; end
      OP_POP:  if (n < 1) e = 1'b1; else d = mq.pop_back();
      OP_ADD, OP_SUB, OP_AND: begin
        if (n < 2) e = 1'b1;
        else begin
          a = mq.pop_back();
          b = mq.pop_back();
          if (op == OP_ADD) r = b + a;
          else if (op == OP_SUB) r = b - a;
          else r = b & a;
          mq.push_back(r);
          d = r;
        end
      end
      OP_NOT: if (n < 1) e = 1'b1; else begin r = ~mq.pop_back(); mq.push_back(r); d = r; end
      OP_DUP: if (n == DEPTH) e = 1'b1; else begin r = mq[$]; mq.push_back(r); d = r; end
      default: begin
`ifdef STACK_SEQ_SWAP_EN
        if (n < 2) e = 1'b1;
        else begin
          a = mq.pop_back();
          b = mq.pop_back();
          mq.push_back(a);
          mq.push_back(b);
          d = b;
        end
`else
        e = 1'b1;
`endif
      end
    endcase
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] data;
    logic       err;
    logic [5:0] dep;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic [2:0] op, input logic [7:0] imm,
                                  input logic [7:0] data, input logic err, input int dep);
    vec_t v;
    v.op = op;
    v.imm = imm;
    v.data = data;
    v.err = err;
    v.dep = 6'(dep);
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, ed;
    logic e, ee;
    int nstb, multi, rsps;
    logic [2:0] op;
    logic [7:0] imm;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_imm = '0;
    #3;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_err", int'(rsp_err), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_strobes", int'({stk_push, stk_pop, stk_tos}), 0);
    check("rst_din", int'(stk_din), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: {op, imm, expected data, expected err, expected depth}
    add_vec(OP_PUSH, 8'h05, 8'h05, 1'b0, 1);
    add_vec(OP_PUSH, 8'h03, 8'h03, 1'b0, 2);
    add_vec(OP_SUB,  8'h00, 8'h02, 1'b0, 1);
    add_vec(OP_POP,  8'h00, 8'h02, 1'b0, 0);
    add_vec(OP_PUSH, 8'h03, 8'h03, 1'b0, 1);
    add_vec(OP_PUSH, 8'h05, 8'h05, 1'b0, 2);
    add_vec(OP_SUB,  8'h00, 8'hFE, 1'b0, 1);
    add_vec(OP_PUSH, 8'h03, 8'h03, 1'b0, 2);
    add_vec(OP_ADD,  8'h00, 8'h01, 1'b0, 1);
    add_vec(OP_POP,  8'h00, 8'h01, 1'b0, 0);
    add_vec(OP_POP,  8'h00, 8'h00, 1'b1, 0);
    add_vec(OP_NOT,  8'h00, 8'h00, 1'b1, 0);
    add_vec(OP_PUSH, 8'h11, 8'h11, 1'b0, 1);
    add_vec(OP_ADD,  8'h00, 8'h00, 1'b1, 1);
    add_vec(OP_AND,  8'h00, 8'h00, 1'b1, 1);
    add_vec(OP_PUSH, 8'h0F, 8'h0F, 1'b0, 2);
    add_vec(OP_NOT,  8'h00, 8'hF0, 1'b0, 2);
    add_vec(OP_DUP,  8'h00, 8'hF0, 1'b0, 3);
    add_vec(OP_POP,  8'h00, 8'hF0, 1'b0, 2);
    add_vec(OP_POP,  8'h00, 8'hF0, 1'b0, 1);
    add_vec(OP_PUSH, 8'h3C, 8'h3C, 1'b0, 2);
    add_vec(OP_AND,  8'h00, 8'h10, 1'b0, 1);
    add_vec(OP_POP,  8'h00, 8'h10, 1'b0, 0);
    add_vec(OP_PUSH, 8'h01, 8'h01, 1'b0, 1);
    add_vec(OP_PUSH, 8'h02, 8'h02, 1'b0, 2);
`ifdef STACK_SEQ_SWAP_EN
    add_vec(OP_SWAP, 8'h00, 8'h01, 1'b0, 2);
    add_vec(OP_POP,  8'h00, 8'h01, 1'b0, 1);
    add_vec(OP_POP,  8'h00, 8'h02, 1'b0, 0);
`else
    add_vec(OP_SWAP, 8'h00, 8'h00, 1'b1, 2);
    add_vec(OP_POP,  8'h00, 8'h02, 1'b0, 1);
    add_vec(OP_POP,  8'h00, 8'h01, 1'b0, 0);
`endif

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].imm, d, e, nstb, multi);
      check($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].data));
      check($sformatf("vec%0d_err", i), int'(e), int'(vecs[i].err));
      check($sformatf("vec%0d_depth", i), int'(depth), int'(vecs[i].dep));
      check($sformatf("vec%0d_strobes", i), nstb, exp_strobes(vecs[i].op, vecs[i].err));
      check($sformatf("vec%0d_onehot", i), multi, 0);
      if (i == 2) begin
        // SUB: pop, pop, idle (operand latch), push in consecutive cycles
        check("sub_trace_len", trace_len, 4);
        check("sub_trace0", int'(trace[0]), 3'b010);
        check("sub_trace1", int'(trace[1]), 3'b010);
        check("sub_trace2", int'(trace[2]), 3'b000);
        check("sub_trace3", int'(trace[3]), 3'b100);
      end
    end

    // Full stack: overflow rejects PUSH/DUP, but POP and binary ops still work
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_cmd(OP_PUSH, 8'(i), d, e, nstb, multi);
    check("full_depth", int'(depth), 32);
    run_cmd(OP_PUSH, 8'hAA, d, e, nstb, multi);
    check("full_push_err", int'(e), 1);
    check("full_push_strobes", nstb, 0);
    check("full_push_depth", int'(depth), 32);
    run_cmd(OP_DUP, 8'h00, d, e, nstb, multi);
    check("full_dup_err", int'(e), 1);
    check("full_dup_depth", int'(depth), 32);
    run_cmd(OP_POP, 8'h00, d, e, nstb, multi);
    check("full_pop_data", int'(d), 8'h1F);
    check("full_pop_err", int'(e), 0);
    check("full_pop_depth", int'(depth), 31);
    run_cmd(OP_PUSH, 8'h02, d, e, nstb, multi);
    check("refill_depth", int'(depth), 32);
    run_cmd(OP_ADD, 8'h00, d, e, nstb, multi);
    check("full_add_data", int'(d), 8'h20);
    check("full_add_err", int'(e), 0);
    check("full_add_depth", int'(depth), 31);

    // cmd_valid held high through a busy DUP: exactly one acceptance
    do_reset();
    run_cmd(OP_PUSH, 8'h0F, d, e, nstb, multi);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = OP_DUP;
    rsps = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsps++;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("held_valid_rsps", rsps, 1);
    check("held_valid_depth", int'(depth), 2);
    run_cmd(OP_POP, 8'h00, d, e, nstb, multi);
    check("held_valid_pop", int'(d), 8'h0F);
    check("held_valid_pop_depth", int'(depth), 1);

    // Asynchronous reset mid-command abandons it with no response
    do_reset();
    run_cmd(OP_PUSH, 8'h05, d, e, nstb, multi);
    run_cmd(OP_PUSH, 8'h03, d, e, nstb, multi);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = OP_SUB;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_depth", int'(depth), 0);
    check("midrst_pop", int'(stk_pop), 0);
    @(negedge clk);
    rst = 1'b0;
    rsps = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) rsps++;
    end
    check("midrst_no_rsp", rsps, 0);

    // Randomized commands against the queue model
    do_reset();
    mq.delete();
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, (i < 200) ? 1 : 3) == 0) op = OP_PUSH;
      if (op == OP_DUP && mq.size() == 0) op = OP_PUSH;
      imm = 8'($urandom);
      model_cmd(op, imm, ed, ee);
      run_cmd(op, imm, d, e, nstb, multi);
      check($sformatf("rnd%0d_op%0d_data", i, op), int'(d), int'(ed));
      check($sformatf("rnd%0d_op%0d_err", i, op), int'(e), int'(ee));
      check($sformatf("rnd%0d_op%0d_depth", i, op), int'(depth), mq.size());
      check($sformatf("rnd%0d_op%0d_strobes", i, op), nstb, exp_strobes(op, ee));
      check($sformatf("rnd%0d_op%0d_onehot", i, op), multi, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Command sequencer in front of the 8-bit hardware stack.
- Accepts one stack-machine command at a time (PUSH, POP, ADD, SUB, AND, NOT, DUP) over a valid/ready handshake.
- Expands each command into push/pop/tos strobe sequences, including the ALU step.
- Tracks stack occupancy so underflow and overflow are rejected before any stack access.

Parameters:
DW, 8, data width; matches stack word width
DEPTH, 32, stack capacity in words
DEPTH_W, 6, occupancy counter width; must hold 0..DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer idle, command accepted when valid&ready
cmd_op  in  3  000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 DUP, 111 SWAP (optional)
cmd_imm  in  DW  PUSH immediate
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DW  command result
rsp_err  out  1  qualified by rsp_valid; command rejected
depth  out  DEPTH_W  current occupancy
stk_push  out  1  to stack push
stk_pop  out  1  to stack pop
stk_tos  out  1  to stack tos
stk_din  out  DW  to stack d_in
stk_dout  in  DW  from stack d_out; registered, valid the cycle after pop/tos

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, depth=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - All stk_* strobes = 0, stk_din=0.
  - The stack's internal pointer is not recovered: rst is asserted only alongside a stack reinitialisation. Reset mid-command abandons the command with no response.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - Commands are accepted on the rising edge with cmd_valid&cmd_ready; cmd_valid while busy is ignored.
- Strobes:
  - stk_* are Moore decodes of the state; at most one asserts per cycle.
  - stk_din = cmd_imm (captured at accept) in a PUSH write, otherwise the result register.
- States: IDLE, RD1 (pop), RD2 (pop, capture A=stk_dout), TOS (tos), LAT (capture last operand), WR (push result), WR2 (second push, SWAP only), RSP.
- Sequences after accept:
  - PUSH: WR -> RSP
  - POP: RD1 -> LAT -> RSP
  - ADD/SUB/AND: RD1 -> RD2 -> LAT -> WR -> RSP
  - NOT: RD1 -> LAT -> WR -> RSP
  - DUP: TOS -> LAT -> WR -> RSP
- RSP lasts one cycle: rsp_valid=1, then IDLE. The next command can be accepted the cycle after RSP.
- Operands:
  - A = top (first popped), B = under-top (second popped).
  - ADD = B+A, SUB = B-A, AND = B&A, NOT = ~A, all modulo 2^DW; no carry or borrow flags.
- rsp_data by command:
  - PUSH: the immediate.
  - POP: the popped value.
  - ALU/DUP: the value pushed.
  - Errors: 0.
- depth is updated on the edge entering RSP. Deltas: PUSH +1, POP -1, binary op -1, NOT 0, DUP +1, SWAP 0.
- Errors, checked at accept against depth:
  - POP/NOT with depth<1: error.
  - ADD/SUB/AND/SWAP with depth<2: error.
  - PUSH/DUP with depth==DEPTH: error.
  - On error: go directly to RSP with rsp_err=1; no stk_* strobe, depth unchanged.
- Boundaries:
  - depth never wraps.
  - A full stack still accepts POP and binary ops.
  - An empty stack still accepts PUSH.

Optional Feature:
- Macro STACK_SEQ_SWAP_EN.
- Defined: opcode 111 = SWAP.
  - Sequence RD1 -> RD2 -> LAT -> WR (push A) -> WR2 (push B) -> RSP.
  - The new top is B; rsp_data = B; depth unchanged; needs depth>=2.
- Undefined: opcode 111 is illegal; RSP with rsp_err=1 and no stack activity; WR2 state is absent.

Test Plan:
- Reset, PUSH 0x05, PUSH 0x03, SUB -> rsp_data=0x02, rsp_err=0, depth=1. SUB shows pop, pop, idle, push strobes in 4 consecutive cycles.
- PUSH 0x03, PUSH 0x05, SUB -> 0xFE. Then PUSH 0x03, ADD -> 0x01 (wrap); depth=1.
- After reset, POP -> rsp_err=1, no stk_* strobe, depth=0. PUSH 0x11, ADD -> rsp_err=1, depth stays 1.
- 32x PUSH i -> depth=32. 33rd PUSH -> rsp_err=1. DUP -> rsp_err=1. POP -> rsp_data=0x1F, depth=31.
- PUSH 0x0F, NOT -> 0xF0. DUP -> 0xF0, depth=2. POP, POP -> 0xF0, 0xF0, depth=0. cmd_valid held high during a busy command -> accepted only once.
- With STACK_SEQ_SWAP_EN: PUSH 0x01, PUSH 0x02, SWAP, POP -> 0x01, POP -> 0x02. Without it: opcode 111 -> rsp_err=1, depth=2.
